// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the priority event encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package prio_enc_pkg;

    // Two-state controller: waiting for a vector, or draining pending bits.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Every pending bit clears to this value on reset.
    localparam logic PEND_RST_BIT = 1'b0;

endpackage

// File: rtl/lsb_index_finder.sv
// Finds the lowest set bit of a vector, whether any bit is set, and its popcount.
// Latency: purely combinational.
// Backpressure: none; the caller registers the input.
module lsb_index_finder #(
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic [IDX_W:0]   cnt_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    // Population count; its width IDX_W+1 holds WIDTH even when WIDTH is a power of two.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + {{IDX_W{1'b0}}, vec_i[i]};
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/priority_event_encoder.sv
// Captures a multi-hot request vector and emits the index of each set bit, bit 0 first.
// Latency: first index valid the cycle after the vector is accepted; one index per cycle after that.
// Backpressure: req_ready_out is low while draining; idx_ready_in low holds the current index stable.
module priority_event_encoder
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] req_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid_out,
    input  logic             idx_ready_in,
    output logic             last_out,
    output logic [IDX_W:0]   remaining_out,
    output logic             zero_drop_out
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             zero_drop_q, zero_drop_d;

    logic [IDX_W-1:0] lsb_idx;
    logic             pend_any;
    logic [IDX_W:0]   pend_cnt;
    logic             busy;

    lsb_index_finder #(
        .WIDTH (WIDTH)
    ) u_lsb (
        .vec_i (pend_q),
        .idx_o (lsb_idx),
        .any_o (pend_any),
        .cnt_o (pend_cnt)
    );

    assign busy = (state_q == BUSY);

    // Next-state: capture nonzero vectors in IDLE, retire the lowest pending bit per handshake in BUSY.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    if (|req_in) begin
                        pend_d  = req_in;
                        state_d = BUSY;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (idx_ready_in) begin
                    // x & (x-1) clears exactly the lowest set bit, the one being presented.
                    pend_d = pend_q & (pend_q - WIDTH'(1));
                    if (pend_cnt == (IDX_W+1)'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = {WIDTH{PEND_RST_BIT}};
            end
        endcase
    end

    // State register; reset drops any partially served vector.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            pend_q      <= {WIDTH{PEND_RST_BIT}};
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    // Outputs depend only on registered state, so there is no input-to-output path.
    always_comb begin
        req_ready_out = ~busy;
        idx_valid_out = busy & pend_any;
        idx_out       = busy ? lsb_idx : '0;
        last_out      = busy & (pend_cnt == (IDX_W+1)'(1));
        remaining_out = busy ? pend_cnt : '0;
        zero_drop_out = zero_drop_q;
    end

endmodule
